// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type, used by vga_sync and the
// Game of Life renderer so both agree on frame geometry.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;
  localparam coord_t COORD_ONE = coord_t'(1);

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int span_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = span_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_sync.sv
// VGA raster timing: pixel/line counters advanced by pix_en, with registered
// sync, blanking and tick outputs aligned to the counter values.
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_MAX    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_MAX    = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   line_tick_q, line_tick_d;
  logic   frame_tick_q, frame_tick_d;

  // >= rather than == so a counter can never run past its last position
  always_comb begin
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    if (pix_en) begin
      if (h_cnt_q >= H_MAX) begin
        h_cnt_d     = '0;
        line_tick_d = 1'b1;
        if (v_cnt_q >= V_MAX) begin
          v_cnt_d      = '0;
          frame_tick_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + COORD_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + COORD_ONE;
      end
    end
  end

  // Decode from the next counter values so outputs land on the same edge
  always_comb begin
    video_on_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    hsync_d    = !((h_cnt_d >= HS_START) && (h_cnt_d <= HS_END));
    vsync_d    = !((v_cnt_d >= VS_START) && (v_cnt_d <= VS_END));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x          = h_cnt_q;
  assign y          = v_cnt_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-geometry instance for line timing and a
// small-geometry instance for whole-frame behaviour, both against a pixel-index model.
module tb_vga_sync;

  localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVV = 6, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en = 1'b0;

  logic hs_a, vs_a, von_a, lt_a, ft_a;
  logic [9:0] x_a, y_a;
  logic hs_b, vs_b, von_b, lt_b, ft_b;
  logic [9:0] x_b, y_b;

  int errors = 0;
  int checks = 0;
  int pa = 0;
  int pb = 0;

  always #5 clk = ~clk;

  vga_sync dut_a (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .x(x_a), .y(y_a),
    .line_tick(lt_a), .frame_tick(ft_a)
  );

  vga_sync #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .x(x_b), .y(y_b),
    .line_tick(lt_b), .frame_tick(ft_b)
  );

  // Expected outputs after p enabled pixels since reset: {x, y, hsync, vsync, video_on, line_tick, frame_tick}
  function automatic logic [24:0] model(input int p, input int hv, input int hf, input int hs,
                                        input int hb, input int vv, input int vf, input int vs,
                                        input int vb, input logic en_edge);
    int ht, vt, px, py;
    logic [9:0] xv, yv;
    logic hsn, vsn, von, lt, ft;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    px  = p % ht;
    py  = (p / ht) % vt;
    xv  = px[9:0];
    yv  = py[9:0];
    hsn = !(px >= hv + hf && px < hv + hf + hs);
    vsn = !(py >= vv + vf && py < vv + vf + vs);
    von = (px < hv) && (py < vv);
    lt  = en_edge && (px == 0);
    ft  = en_edge && (px == 0) && (py == 0);
    return {xv, yv, hsn, vsn, von, lt, ft};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input logic en_edge, input string tag);
    logic [24:0] ea, eb;
    ea = model(pa, 640, 16, 96, 48, 480, 10, 2, 33, en_edge);
    eb = model(pb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, en_edge);
    chk({tag, "_a"}, {7'd0, x_a, y_a, hs_a, vs_a, von_a, lt_a, ft_a}, {7'd0, ea});
    chk({tag, "_b"}, {7'd0, x_b, y_b, hs_b, vs_b, von_b, lt_b, ft_b}, {7'd0, eb});
  endtask

  task automatic step(input logic en, input string tag);
    @(negedge clk);
    pix_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      pa++;
      pb++;
    end
    check_both(en, tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    pix_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    pa = 0;
    pb = 0;
    check_both(1'b0, tag);
    chk({tag, "_hsync_const"}, {31'd0, hs_a}, 32'd1);
    chk({tag, "_vonb_const"}, {31'd0, von_b}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int low, first_low, ticks, tick_x, en_cnt, cyc, vlow, ftk, vmin, vmax;
    logic en;

    // Reset from power-up
    repeat (3) @(posedge clk);
    #1;
    check_both(1'b0, "por");
    @(negedge clk);
    reset_n = 1'b1;

    // Random enable pattern, then reset mid-frame without a clock edge
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), "rand");
    async_reset("midreset");
    step(1'b1, "post_reset");
    chk("post_reset_x", {22'd0, x_a}, 32'd1);
    chk("post_reset_y", {22'd0, y_a}, 32'd0);
    chk("post_reset_xb", {22'd0, x_b}, 32'd1);

    // One full default line with pix_en on every 4th clock
    low = 0; first_low = -1; ticks = 0; tick_x = -1;
    for (int i = 0; i < 3200; i++) begin
      en = (i % 4 == 3);
      step(en, "line4");
      if (en) begin
        if (!hs_a) begin
          low++;
          if (first_low < 0) first_low = int'(x_a);
        end
        if (lt_a) begin
          ticks++;
          tick_x = int'(x_a);
        end
      end
    end
    chk("hsync_low_count", low, 32'd96);
    chk("hsync_first_x", first_low, 32'd656);
    chk("line_tick_count", ticks, 32'd1);
    chk("line_tick_x", tick_x, 32'd0);

    // One full small frame with random enables
    en_cnt = 0; cyc = 0; vlow = 0; ftk = 0; vmin = 1000; vmax = -1;
    while (en_cnt < BHT * BVT && cyc < 5000) begin
      en = 1'($urandom_range(0, 1));
      step(en, "frame");
      cyc++;
      if (en) begin
        en_cnt++;
        if (!vs_b) begin
          vlow++;
          if (int'(y_b) < vmin) vmin = int'(y_b);
          if (int'(y_b) > vmax) vmax = int'(y_b);
        end
        if (ft_b) ftk++;
      end
    end
    chk("frame_budget", en_cnt, BHT * BVT);
    chk("vsync_low_pixels", vlow, BVS * BHT);
    chk("vsync_low_ymin", vmin, BVV + BVF);
    chk("vsync_low_ymax", vmax, BVV + BVF + BVS - 1);
    chk("frame_tick_count", ftk, 32'd1);

    // Continuous enable across several small-frame wraps
    for (int i = 0; i < 500; i++) step(1'b1, "cont");

    // Visible-region boundaries on the small instance
    async_reset("midreset2");
    for (int i = 0; i < (BVV - 1) * BHT + BHV - 1; i++) step(1'b1, "seek");
    chk("von_last_xy", {12'd0, x_b, y_b}, {12'd0, 10'(BHV - 1), 10'(BVV - 1)});
    chk("von_last", {31'd0, von_b}, 32'd1);
    step(1'b1, "von_edge");
    chk("von_past_x", {31'd0, von_b}, 32'd0);
    for (int i = 0; i < BHT - BHV; i++) step(1'b1, "seek");
    chk("von_row_xy", {12'd0, x_b, y_b}, {12'd0, 10'd0, 10'(BVV)});
    chk("von_past_y", {31'd0, von_b}, 32'd0);

    // Park at the last pixel of the frame, hold, then wrap
    while (pb < BHT * BVT - 1) step(1'b1, "seek");
    chk("park_xy", {12'd0, x_b, y_b}, {12'd0, 10'(BHT - 1), 10'(BVT - 1)});
    for (int i = 0; i < 50; i++) begin
      step(1'b0, "hold");
      chk("hold_x", {22'd0, x_b}, BHT - 1);
      chk("hold_ticks", {30'd0, lt_b, ft_b}, 32'd0);
    end
    step(1'b1, "wrap");
    chk("wrap_xy", {12'd0, x_b, y_b}, 32'd0);
    chk("wrap_ticks", {30'd0, lt_b, ft_b}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
